// File: rtl/sdram_seq_pkg.sv
// Shared types and helpers for the SDRAM burst sequencer.
// Optional overlapped issue is enabled by defining SDRAM_BURST_SEQ_OVERLAP_EN.
package sdram_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        SETTLE = 3'd2,
        DRAIN  = 3'd3,
        NEXT   = 3'd4
    } state_e;

    // Cycles held after ctl_go so the master's done flag has time to drop.
    localparam int SETTLE_CYCLES = 2;

    function automatic logic [31:0] bytes_per_burst(input int burst_words, input int data_w);
        return 32'(burst_words * (data_w / 8));
    endfunction

endpackage

// File: rtl/sdram_seq_addr_gen.sv
// Burst index and strided base address register for the SDRAM burst sequencer.
// restart reloads burst 0 / START_BASE; advance steps to the next burst.
module sdram_seq_addr_gen
    import sdram_seq_pkg::*;
#(
    parameter int          NUM_BURSTS   = 4,
    parameter logic [31:0] START_BASE   = 32'h0000_0000,
    parameter logic [31:0] STRIDE_BYTES = 32'h0000_0100,
    localparam int         IDX_W        = $clog2(NUM_BURSTS) + 1
) (
    input  logic             CLOCK_50,
    input  logic             reset_reset_n,
    input  logic             restart,
    input  logic             advance,
    output logic [IDX_W-1:0] burst_idx,
    output logic [31:0]      read_base,
    output logic             last_burst
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge CLOCK_50 or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            burst_idx <= '0;
            read_base <= '0;
        end else if (restart) begin
            burst_idx <= '0;
            read_base <= START_BASE;
        end else if (advance) begin
            burst_idx <= burst_idx + 1'b1;
            read_base <= read_base + STRIDE_BYTES;  // 32-bit wrap is intended
        end
    end

    assign last_burst = (burst_idx == IDX_W'(NUM_BURSTS - 1));

endmodule

// File: rtl/sdram_burst_sequencer.sv
// Issues NUM_BURSTS strided read bursts to the Qsys SDRAM read master and drains its
// show-ahead buffer into a valid/ready stream. Optional macro: SDRAM_BURST_SEQ_OVERLAP_EN.
module sdram_burst_sequencer
    import sdram_seq_pkg::*;
#(
    parameter int          DATA_W       = 16,
    parameter int          BURST_WORDS  = 8,
    parameter int          NUM_BURSTS   = 4,
    parameter logic [31:0] START_BASE   = 32'h0000_0000,
    parameter logic [31:0] STRIDE_BYTES = 32'h0000_0100,
    localparam int         IDX_W        = $clog2(NUM_BURSTS) + 1
) (
    input  logic              CLOCK_50,
    input  logic              reset_reset_n,
    input  logic              start,
    input  logic              loop_en,
    input  logic              stop,
    output logic              busy,
    output logic              pass_done,
    output logic [IDX_W-1:0]  burst_idx,
    output logic              ctl_fixed_location,
    output logic [31:0]       ctl_read_base,
    output logic [31:0]       ctl_read_length,
    output logic              ctl_go,
    input  logic              ctl_done,
    input  logic              ctl_early_done,
    output logic              usr_read_buffer,
    input  logic [DATA_W-1:0] usr_buffer_output_data,
    input  logic              usr_data_available,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
`ifdef SDRAM_BURST_SEQ_OVERLAP_EN
    ,
    output logic [15:0]       overlap_cnt
`endif
);

    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_ISSUE  = ISSUE;
    localparam logic [2:0] ST_SETTLE = SETTLE;
    localparam logic [2:0] ST_DRAIN  = DRAIN;
    localparam logic [2:0] ST_NEXT   = NEXT;

    localparam int               CNT_W       = $clog2(BURST_WORDS + 1);
    localparam int               SET_W       = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] WORDS_LIMIT = CNT_W'(BURST_WORDS);

    logic [2:0]       state, state_nxt;
    logic [CNT_W-1:0] word_cnt;
    logic [SET_W-1:0] settle_cnt;
    logic             loop_flag;
    logic             at_limit, restart, advance, last_burst, overlap_go;

    sdram_seq_addr_gen #(
        .NUM_BURSTS   (NUM_BURSTS),
        .START_BASE   (START_BASE),
        .STRIDE_BYTES (STRIDE_BYTES)
    ) u_addr_gen (
        .CLOCK_50      (CLOCK_50),
        .reset_reset_n (reset_reset_n),
        .restart       (restart),
        .advance       (advance),
        .burst_idx     (burst_idx),
        .read_base     (ctl_read_base),
        .last_burst    (last_burst)
    );

    // Words past BURST_WORDS stay in the master's buffer; the stream never sees them.
    assign at_limit           = (word_cnt == WORDS_LIMIT);
    assign out_valid          = (state == ST_DRAIN) && usr_data_available && !at_limit;
    assign out_data           = usr_buffer_output_data;
    assign usr_read_buffer    = out_valid && out_ready;
    assign busy               = (state != ST_IDLE);
    assign ctl_go             = (state == ST_ISSUE);
    assign ctl_fixed_location = 1'b0;
    assign ctl_read_length    = bytes_per_burst(BURST_WORDS, DATA_W);

`ifdef SDRAM_BURST_SEQ_OVERLAP_EN
    // The master has sent its last request and this burst is fully popped, so the
    // next burst may be kicked off without waiting for done.
    assign overlap_go = (state == ST_DRAIN) && at_limit && !ctl_done && ctl_early_done && !last_burst;

    always_ff @(posedge CLOCK_50 or negedge reset_reset_n) begin
        if (!reset_reset_n)
            overlap_cnt <= '0;
        else if (overlap_go && overlap_cnt != 16'hFFFF)
            overlap_cnt <= overlap_cnt + 1'b1;
    end
`else
    logic early_done_unused;
    assign overlap_go        = 1'b0;
    assign early_done_unused = ctl_early_done;
`endif

    // NOTE: every signal written here gets a default first, so no path infers a latch.
    always_comb begin
        state_nxt = state;
        restart   = 1'b0;
        advance   = 1'b0;
        pass_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    restart   = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE:  state_nxt = ST_SETTLE;
            ST_SETTLE: begin
                if (settle_cnt == SET_W'(SETTLE_CYCLES - 1))
                    state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (at_limit && ctl_done) begin
                    state_nxt = ST_NEXT;
                end else if (overlap_go) begin
                    advance   = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_NEXT: begin
                if (!last_burst) begin
                    advance   = 1'b1;
                    state_nxt = ST_ISSUE;
                end else if (loop_flag) begin
                    restart   = 1'b1;
                    state_nxt = ST_ISSUE;
                end else begin
                    pass_done = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state      <= ST_IDLE;
            word_cnt   <= '0;
            settle_cnt <= '0;
            loop_flag  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_ISSUE) begin
                word_cnt   <= '0;
                settle_cnt <= '0;
            end else begin
                if (usr_read_buffer)
                    word_cnt <= word_cnt + 1'b1;
                if (state == ST_SETTLE)
                    settle_cnt <= settle_cnt + 1'b1;
            end
            // A start arriving together with stop still launches, but without looping.
            if (state == ST_IDLE && start)
                loop_flag <= loop_en && !stop;
            else if (stop)
                loop_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sdram_burst_sequencer.sv
// Scoreboard bench for sdram_burst_sequencer with a behavioural read-master model,
// plus a second instance exercising 32-bit base address wrap.
module tb_sdram_burst_sequencer;

    localparam int          DATA_W      = 16;
    localparam int          BURST_WORDS = 8;
    localparam int          NUM_BURSTS  = 4;
    localparam logic [31:0] STRIDE      = 32'h100;
    localparam int          IDX_W       = $clog2(NUM_BURSTS) + 1;
    localparam int          W_IDX_W     = $clog2(2) + 1;

    logic CLOCK_50      = 1'b0;
    logic reset_reset_n = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    logic              start = 1'b0, loop_en = 1'b0, stop = 1'b0;
    logic              busy, pass_done, ctl_fixed_location, ctl_go, usr_read_buffer, out_valid;
    logic [IDX_W-1:0]  burst_idx;
    logic [31:0]       ctl_read_base, ctl_read_length;
    logic [DATA_W-1:0] out_data;
    logic              ctl_done = 1'b1, ctl_early_done = 1'b0, usr_data_available = 1'b0, out_ready = 1'b1;
    logic [DATA_W-1:0] usr_buffer_output_data = '0;

    logic               w_start = 1'b0, w_busy, w_pass_done, w_fixed, w_go, w_read_buffer, w_valid;
    logic [W_IDX_W-1:0] w_idx;
    logic [31:0]        w_base, w_length;
    logic [DATA_W-1:0]  w_out_data;

    sdram_burst_sequencer #(
        .DATA_W(DATA_W), .BURST_WORDS(BURST_WORDS), .NUM_BURSTS(NUM_BURSTS),
        .START_BASE(32'h0), .STRIDE_BYTES(STRIDE)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset_reset_n(reset_reset_n),
        .start(start), .loop_en(loop_en), .stop(stop),
        .busy(busy), .pass_done(pass_done), .burst_idx(burst_idx),
        .ctl_fixed_location(ctl_fixed_location), .ctl_read_base(ctl_read_base),
        .ctl_read_length(ctl_read_length), .ctl_go(ctl_go),
        .ctl_done(ctl_done), .ctl_early_done(ctl_early_done),
        .usr_read_buffer(usr_read_buffer), .usr_buffer_output_data(usr_buffer_output_data),
        .usr_data_available(usr_data_available),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    sdram_burst_sequencer #(
        .DATA_W(DATA_W), .BURST_WORDS(BURST_WORDS), .NUM_BURSTS(2),
        .START_BASE(32'hFFFF_FF00), .STRIDE_BYTES(32'h100)
    ) dut_wrap (
        .CLOCK_50(CLOCK_50), .reset_reset_n(reset_reset_n),
        .start(w_start), .loop_en(1'b0), .stop(1'b0),
        .busy(w_busy), .pass_done(w_pass_done), .burst_idx(w_idx),
        .ctl_fixed_location(w_fixed), .ctl_read_base(w_base),
        .ctl_read_length(w_length), .ctl_go(w_go),
        .ctl_done(1'b1), .ctl_early_done(1'b0),
        .usr_read_buffer(w_read_buffer), .usr_buffer_output_data(16'hA5A5),
        .usr_data_available(1'b1),
        .out_data(w_out_data), .out_valid(w_valid), .out_ready(1'b1)
    );

    int n_tests = 0, n_fail = 0;

    // Scoreboard: expected stream words and burst bases, and observed event counts.
    logic [DATA_W-1:0] exp_data[$];
    logic [31:0]       exp_base[$];
    logic [31:0]       w_exp_base[$];
    int go_cnt = 0, pd_cnt = 0, pop_total = 0, pop_burst = 0, w_go_cnt = 0, w_pd_cnt = 0;
    bit burst_open = 1'b0;

    // Master model knobs and state.
    logic [DATA_W-1:0] mbuf[$];
    int  words_per_burst = BURST_WORDS;
    bit  stall_rand      = 1'b0;
    int  ready_mode      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Read master: one pass = ctl_go, fill buffer at up to one word per cycle, raise done.
    initial begin : master
        logic [DATA_W-1:0] w;
        bit go_s, rb_s;
        int fill_left, fill_idx, done_wait;
        fill_left = 0; fill_idx = 0; done_wait = -1;
        forever begin
            @(negedge CLOCK_50);
            go_s = ctl_go;
            rb_s = usr_read_buffer;
            @(posedge CLOCK_50);
            #1;
            if (!reset_reset_n) begin
                mbuf.delete(); fill_left = 0; done_wait = -1; ctl_done = 1'b1;
            end else begin
                if (rb_s && mbuf.size() > 0) void'(mbuf.pop_front());
                if (go_s) begin
                    mbuf.delete(); fill_left = words_per_burst; fill_idx = 0;
                    ctl_done = 1'b0; done_wait = -1;
                end else if (fill_left > 0) begin
                    if (!stall_rand || $urandom_range(0, 1) == 1) begin
                        w = DATA_W'($urandom);
                        mbuf.push_back(w);
                        if (fill_idx < BURST_WORDS) exp_data.push_back(w);
                        fill_idx++; fill_left--;
                        if (fill_left == 0) done_wait = stall_rand ? int'($urandom_range(0, 3)) : 0;
                    end
                end else if (done_wait > 0) begin
                    done_wait--;
                end else if (done_wait == 0) begin
                    ctl_done = 1'b1; done_wait = -1;
                end
            end
            usr_data_available     = (mbuf.size() > 0);
            usr_buffer_output_data = (mbuf.size() > 0) ? mbuf[0] : '0;
        end
    end

    initial begin : ready_driver
        forever begin
            @(posedge CLOCK_50);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin : monitor
        logic [DATA_W-1:0] e;
        logic [31:0] eb;
        forever begin
            @(negedge CLOCK_50);
            if (!reset_reset_n) begin
                burst_open = 1'b0;
                continue;
            end
            check("read_buffer_eq_handshake", 32'(usr_read_buffer), 32'(out_valid && out_ready));
            if (out_valid) check("valid_implies_busy", 32'(busy), 32'd1);
            if (usr_read_buffer) check("pop_needs_available", 32'(usr_data_available), 32'd1);
            if (ctl_go) begin
                go_cnt++;
                if (burst_open) check("pops_per_burst", 32'(pop_burst), 32'(BURST_WORDS));
                if (exp_base.size() == 0) begin
                    check("unexpected_ctl_go", 32'(exp_base.size()), 32'd1);
                end else begin
                    eb = exp_base.pop_front();
                    check("ctl_read_base", ctl_read_base, eb);
                end
                check("ctl_read_length", ctl_read_length, 32'(BURST_WORDS * DATA_W / 8));
                check("ctl_fixed_location", 32'(ctl_fixed_location), 32'd0);
                burst_open = 1'b1;
                pop_burst  = 0;
            end
            if (out_valid && out_ready) begin
                pop_burst++; pop_total++;
                if (exp_data.size() == 0) begin
                    check("unexpected_word", 32'(exp_data.size()), 32'd1);
                end else begin
                    e = exp_data.pop_front();
                    check("out_data", 32'(out_data), 32'(e));
                end
            end
            if (pass_done) begin
                pd_cnt++;
                if (burst_open) check("pops_per_burst", 32'(pop_burst), 32'(BURST_WORDS));
                burst_open = 1'b0;
            end
        end
    end

    initial begin : wrap_monitor
        logic [31:0] eb;
        forever begin
            @(negedge CLOCK_50);
            if (reset_reset_n && w_go) begin
                w_go_cnt++;
                if (w_exp_base.size() == 0) begin
                    check("wrap_unexpected_go", 32'(w_exp_base.size()), 32'd1);
                end else begin
                    eb = w_exp_base.pop_front();
                    check("wrap_base", w_base, eb);
                end
            end
            if (reset_reset_n && w_pass_done) w_pd_cnt++;
        end
    end

    task automatic push_pass_bases();
        for (int i = 0; i < NUM_BURSTS; i++) exp_base.push_back(32'(i) * STRIDE);
    endtask

    task automatic pulse_start();
        @(posedge CLOCK_50); #1; start = 1'b1;
        @(posedge CLOCK_50); #1; start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        do begin @(negedge CLOCK_50); #1; n++; end while (busy && n < budget);
        check({name, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge CLOCK_50);
    endtask

    initial begin : stimulus
        int g0, p0, t0, lat, n;

        // Reset state
        #5;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ctl_go", 32'(ctl_go), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_pass_done", 32'(pass_done), 32'd0);
        check("rst_burst_idx", 32'(burst_idx), 32'd0);
        check("rst_read_base", ctl_read_base, 32'd0);
        check("rst_read_length", ctl_read_length, 32'd16);
        wait_cycles(3);
        #3 reset_reset_n = 1'b1;
        wait_cycles(2);

        // Single pass, 1 word/cycle, ready always high; a second start mid-pass is ignored
        push_pass_bases();
        g0 = go_cnt; p0 = pd_cnt; t0 = pop_total;
        @(posedge CLOCK_50); #1; start = 1'b1;
        @(posedge CLOCK_50); #1; start = 1'b0;
        lat = 0;
        do begin @(negedge CLOCK_50); lat++; end while (!out_valid && lat < 50);
        check("first_valid_latency_ge4", 32'(lat >= 4), 32'd1);
        pulse_start();
        wait_idle("pass1", 500);
        check("pass1_go_count", 32'(go_cnt - g0), 32'd4);
        check("pass1_pass_done", 32'(pd_cnt - p0), 32'd1);
        check("pass1_words", 32'(pop_total - t0), 32'd32);
        wait_cycles(20);
        check("pass1_no_restart", 32'(go_cnt - g0), 32'd4);

        // Looping with stop raised during burst 2 of the second pass
        push_pass_bases(); push_pass_bases();
        g0 = go_cnt; p0 = pd_cnt;
        loop_en = 1'b1;
        pulse_start();
        n = 0;
        while (go_cnt < g0 + 7 && n < 1000) begin @(negedge CLOCK_50); #1; n++; end
        check("loop_reached_pass2_burst2", 32'(go_cnt - g0), 32'd7);
        @(posedge CLOCK_50); #1; stop = 1'b1;
        @(posedge CLOCK_50); #1; stop = 1'b0;
        wait_idle("loop", 1000);
        loop_en = 1'b0;
        check("loop_go_count", 32'(go_cnt - g0), 32'd8);
        check("loop_pass_done", 32'(pd_cnt - p0), 32'd1);
        wait_cycles(20);
        check("loop_no_further_go", 32'(go_cnt - g0), 32'd8);

        // Back-pressure: out_ready toggles every cycle
        push_pass_bases();
        g0 = go_cnt; p0 = pd_cnt; t0 = pop_total;
        ready_mode = 1;
        pulse_start();
        wait_idle("toggle", 800);
        check("toggle_words", 32'(pop_total - t0), 32'd32);
        check("toggle_pass_done", 32'(pd_cnt - p0), 32'd1);

        // Master delivers 9 words per burst: the 9th is never popped
        push_pass_bases();
        g0 = go_cnt; t0 = pop_total;
        ready_mode = 0; words_per_burst = BURST_WORDS + 1;
        pulse_start();
        wait_idle("extra_word", 800);
        check("extra_word_words", 32'(pop_total - t0), 32'd32);
        check("extra_word_left_in_buffer", 32'(mbuf.size()), 32'd1);
        check("extra_word_go_count", 32'(go_cnt - g0), 32'd4);
        words_per_burst = BURST_WORDS;
        wait_cycles(2);

        // Randomised ready and master fill timing
        ready_mode = 2; stall_rand = 1'b1;
        for (int p = 0; p < 3; p++) begin
            push_pass_bases();
            g0 = go_cnt; p0 = pd_cnt; t0 = pop_total;
            pulse_start();
            wait_idle("random", 2000);
            check("random_words", 32'(pop_total - t0), 32'd32);
            check("random_pass_done", 32'(pd_cnt - p0), 32'd1);
        end
        ready_mode = 0; stall_rand = 1'b0;

        // Reset mid-DRAIN at word 3, then restart from base 0
        push_pass_bases();
        t0 = pop_total;
        pulse_start();
        n = 0;
        while (pop_total < t0 + 3 && n < 200) begin @(negedge CLOCK_50); #1; n++; end
        check("reached_word3", 32'(pop_total - t0), 32'd3);
        #2 reset_reset_n = 1'b0;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_read_buffer", 32'(usr_read_buffer), 32'd0);
        check("async_rst_ctl_go", 32'(ctl_go), 32'd0);
        check("async_rst_burst_idx", 32'(burst_idx), 32'd0);
        check("async_rst_read_base", ctl_read_base, 32'd0);
        wait_cycles(3);
        exp_data.delete(); exp_base.delete();
        #3 reset_reset_n = 1'b1;
        wait_cycles(2);
        push_pass_bases();
        g0 = go_cnt; p0 = pd_cnt; t0 = pop_total;
        pulse_start();
        wait_idle("after_reset", 500);
        check("after_reset_go_count", 32'(go_cnt - g0), 32'd4);
        check("after_reset_words", 32'(pop_total - t0), 32'd32);
        check("after_reset_pass_done", 32'(pd_cnt - p0), 32'd1);

        // Base address wraps past 0xFFFFFFFF
        w_exp_base.push_back(32'hFFFF_FF00);
        w_exp_base.push_back(32'h0000_0000);
        @(posedge CLOCK_50); #1; w_start = 1'b1;
        @(posedge CLOCK_50); #1; w_start = 1'b0;
        n = 0;
        do begin @(negedge CLOCK_50); #1; n++; end while (w_busy && n < 300);
        check("wrap_busy_after", 32'(w_busy), 32'd0);
        check("wrap_go_count", 32'(w_go_cnt), 32'd2);
        check("wrap_pass_done", 32'(w_pd_cnt), 32'd1);
        check("wrap_read_length", w_length, 32'd16);

        check("leftover_bases", 32'(exp_base.size()), 32'd0);
        check("leftover_words", 32'(exp_data.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
